// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master modport is the requester side, the slave modport is the adder.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial adder that reuses one 4-bit carry-lookahead slice for every nibble,
// producing a W-bit sum plus carry-out and signed overflow after NIBBLES cycles.
module nibble_cla (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] z,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Carries are flattened so no bit waits on the previous one.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign z    = p ^ c[3:0];
  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          carry;
  logic [W-1:0]  sum_r;
  logic          cout_r;
  logic          ovf_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;

  logic [KW+1:0] lo;
  logic [3:0]    x;
  logic [3:0]    y;
  logic [3:0]    z;
  logic          slice_cout;
  logic          carry_into_msb;

  assign lo = {k, 2'b00};
  assign x  = a_r[lo +: 4];
  assign y  = b_r[lo +: 4];

  nibble_cla u_cla (
    .x    (x),
    .y    (y),
    .cin  (carry),
    .z    (z),
    .cout (slice_cout)
  );

  // The carry into bit 3 of the slice is recoverable from its sum bit.
  assign carry_into_msb = z[3] ^ x[3] ^ y[3];

  // in_ready stays low until the first edge after reset so nothing is
  // accepted while the block is still coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      a_r         <= '0;
      b_r         <= '0;
      carry       <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready_r && bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            carry      <= bus.cin;
            k          <= '0;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          sum_r[lo +: 4] <= z;
          carry          <= slice_cout;
          if (k == LAST) begin
            cout_r      <= slice_cout;
            ovf_r       <= carry_into_msb ^ slice_cout;
            state       <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.busy      = busy_r;
endmodule
